// File: rtl/main.sv
// PS/2 keypad single-digit adder: receives scan codes, runs A + B = R entry FSM, drives six 7-seg displays.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity frame rejection.
module main (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyb_clk,
  input  logic       keyb_data,
  output logic [6:0] hex7,
  output logic [6:0] hex6,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // [0],[1] synchronize; [2] holds the previous synchronized clock for edge detection
  logic [2:0] r_kc;
  logic [1:0] r_kd;
  logic       w_kc_rise, w_kd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_kc <= 3'b111;
      r_kd <= 2'b11;
    end else begin
      r_kc <= {r_kc[1:0], keyb_clk};
      r_kd <= {r_kd[0], keyb_data};
    end
  end

  assign w_kc_rise = r_kc[1] & ~r_kc[2];
  assign w_kd      = r_kd[1];

  logic        r_busy;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [11:0] r_tmo;
  logic        r_rx_vld;
  logic [7:0]  r_rx_byte;
  logic        w_par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  // bitcnt 1..8 data, 9 parity, 10 stop
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_tmo     <= 12'd0;
      r_rx_vld  <= 1'b0;
      r_rx_byte <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_rx_vld <= 1'b0;
      if (w_kc_rise) begin
        r_tmo <= 12'd0;
        if (!r_busy) begin
          if (!w_kd) begin
            r_busy   <= 1'b1;
            r_bitcnt <= 4'd1;
          end
        end else if (r_bitcnt <= 4'd8) begin
          r_shift  <= {w_kd, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end else if (r_bitcnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
          r_par    <= w_kd;
`endif
          r_bitcnt <= 4'd10;
        end else begin
          r_busy   <= 1'b0;
          r_bitcnt <= 4'd0;
          if (w_kd && w_par_ok) begin
            r_rx_vld  <= 1'b1;
            r_rx_byte <= r_shift;
          end
        end
      end else if (r_busy) begin
        if (r_tmo == 12'hFFF) begin
          r_busy   <= 1'b0;
          r_bitcnt <= 4'd0;
          r_tmo    <= 12'd0;
        end else begin
          r_tmo <= r_tmo + 12'd1;
        end
      end
    end
  end

  logic       w_is_digit, w_plus, w_equals, w_clear;
  logic [3:0] w_digit;

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (r_rx_byte)
      8'h70: w_digit = 4'd0;  8'h69: w_digit = 4'd1;
      8'h72: w_digit = 4'd2;  8'h7A: w_digit = 4'd3;
      8'h6B: w_digit = 4'd4;  8'h73: w_digit = 4'd5;
      8'h74: w_digit = 4'd6;  8'h6C: w_digit = 4'd7;
      8'h75: w_digit = 4'd8;  8'h7D: w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  assign w_plus   = (r_rx_byte == 8'h79);
  assign w_equals = (r_rx_byte == 8'h55);
  assign w_clear  = (r_rx_byte == 8'h76);

  state_t     r_state, w_state;
  logic [3:0] r_a, r_b, w_a, w_b;
  logic [4:0] r_r, w_r;
  logic       r_av, r_bv, r_brk, r_code_vld;
  logic       w_av, w_bv, w_brk, w_code_vld;
  logic [7:0] r_code, w_code;

  always_comb begin
    w_state    = r_state;
    w_a        = r_a;
    w_b        = r_b;
    w_r        = r_r;
    w_av       = r_av;
    w_bv       = r_bv;
    w_brk      = r_brk;
    w_code     = r_code;
    w_code_vld = r_code_vld;
    if (r_rx_vld) begin
      w_code     = r_rx_byte;
      w_code_vld = 1'b1;
      if (r_brk) begin
        w_brk = 1'b0;
      end else if (r_rx_byte == 8'hF0) begin
        w_brk = 1'b1;
      end else if (w_clear) begin
        w_state = ENTER_A;
        w_a = 4'd0;  w_b = 4'd0;  w_r = 5'd0;
        w_av = 1'b0; w_bv = 1'b0;
      end else begin
        case (r_state)
          ENTER_A: begin
            if (w_is_digit) begin
              w_a  = w_digit;
              w_av = 1'b1;
            end else if (w_plus && r_av) begin
              w_state = ENTER_B;
            end
          end
          ENTER_B: begin
            if (w_is_digit) begin
              w_b  = w_digit;
              w_bv = 1'b1;
            end else if (w_equals && r_bv) begin
              w_r     = {1'b0, r_a} + {1'b0, r_b};
              w_state = SHOW;
            end
          end
          SHOW: begin
            if (w_is_digit) begin
              w_a = w_digit; w_av = 1'b1;
              w_b = 4'd0;    w_bv = 1'b0;
              w_r = 5'd0;
              w_state = ENTER_A;
            end else if (w_plus) begin
              w_b = 4'd0; w_bv = 1'b0;
              w_r = 5'd0;
              w_state = ENTER_B;
            end
          end
          default: w_state = ENTER_A;
        endcase
      end
    end
  end

  logic [3:0] w_tens, w_units;
  assign w_tens  = (w_r >= 5'd10) ? 4'd1 : 4'd0;
  assign w_units = (w_r >= 5'd10) ? 4'(w_r - 5'd10) : w_r[3:0];

  logic [6:0] r_hex7, r_hex6, r_hex5, r_hex4, r_hex1, r_hex0;

  // displays are built from next-state values so they land on the same edge as the key action
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ENTER_A;
      r_a        <= 4'd0;
      r_b        <= 4'd0;
      r_r        <= 5'd0;
      r_av       <= 1'b0;
      r_bv       <= 1'b0;
      r_brk      <= 1'b0;
      r_code     <= 8'h00;
      r_code_vld <= 1'b0;
      r_hex7 <= BLANK; r_hex6 <= BLANK; r_hex5 <= BLANK;
      r_hex4 <= BLANK; r_hex1 <= BLANK; r_hex0 <= BLANK;
    end else begin
      r_state    <= w_state;
      r_a        <= w_a;
      r_b        <= w_b;
      r_r        <= w_r;
      r_av       <= w_av;
      r_bv       <= w_bv;
      r_brk      <= w_brk;
      r_code     <= w_code;
      r_code_vld <= w_code_vld;
      r_hex7 <= w_code_vld ? seg7(w_code[7:4]) : BLANK;
      r_hex6 <= w_code_vld ? seg7(w_code[3:0]) : BLANK;
      r_hex5 <= w_av ? seg7(w_a) : BLANK;
      r_hex4 <= w_bv ? seg7(w_b) : BLANK;
      r_hex1 <= (w_state == SHOW) ? seg7(w_tens)  : BLANK;
      r_hex0 <= (w_state == SHOW) ? seg7(w_units) : BLANK;
    end
  end

  assign hex7 = r_hex7;
  assign hex6 = r_hex6;
  assign hex5 = r_hex5;
  assign hex4 = r_hex4;
  assign hex1 = r_hex1;
  assign hex0 = r_hex0;

endmodule

// File: tb/tb_main.sv
// Bench for main: directed PS/2 sequences plus random frames checked against a key-level model.
module tb_main;
  logic clk = 1'b0, reset = 1'b0, keyb_clk = 1'b1, keyb_data = 1'b1;
  logic [6:0] hex7, hex6, hex5, hex4, hex1, hex0;

  main dut (.clk(clk), .reset(reset), .keyb_clk(keyb_clk), .keyb_data(keyb_data),
            .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4), .hex1(hex1), .hex0(hex0));

  always #5 clk = ~clk;

  localparam int HP = 8;
  int n_chk = 0, n_fail = 0;

  logic [6:0] GLY  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] KEYS [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] PICK [14] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                            8'h79, 8'h55, 8'h79, 8'h55};

  // model: mode 0 = entering A, 1 = entering B, 2 = showing result
  int m_mode, m_a, m_b, m_r;
  bit m_av, m_bv, m_brk, m_cv;
  logic [7:0] m_code;

  task automatic model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_r = 0;
    m_av = 0; m_bv = 0; m_brk = 0; m_cv = 0; m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int d;
    m_code = b; m_cv = 1;
    d = -1;
    for (int i = 0; i < 10; i++) if (KEYS[i] == b) d = i;
    if (m_brk) m_brk = 0;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h76) begin
      m_mode = 0; m_a = 0; m_b = 0; m_r = 0; m_av = 0; m_bv = 0;
    end else if (d >= 0) begin
      if (m_mode == 0) begin m_a = d; m_av = 1; end
      else if (m_mode == 1) begin m_b = d; m_bv = 1; end
      else begin m_a = d; m_av = 1; m_b = 0; m_bv = 0; m_r = 0; m_mode = 0; end
    end else if (b == 8'h79) begin
      if (m_mode == 0 && m_av) m_mode = 1;
      else if (m_mode == 2) begin m_mode = 1; m_b = 0; m_bv = 0; end
    end else if (b == 8'h55) begin
      if (m_mode == 1 && m_bv) begin m_r = m_a + m_b; m_mode = 2; end
    end
  endtask

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hex7"}, hex7, m_cv ? GLY[m_code[7:4]] : 7'h7F);
    check({tag, ".hex6"}, hex6, m_cv ? GLY[m_code[3:0]] : 7'h7F);
    check({tag, ".hex5"}, hex5, m_av ? GLY[m_a] : 7'h7F);
    check({tag, ".hex4"}, hex4, m_bv ? GLY[m_b] : 7'h7F);
    check({tag, ".hex1"}, hex1, (m_mode == 2) ? GLY[m_r / 10] : 7'h7F);
    check({tag, ".hex0"}, hex0, (m_mode == 2) ? GLY[m_r % 10] : 7'h7F);
  endtask

  // data changes on the falling edge, is sampled by the DUT on the rising edge
  task automatic send_bit(input logic v);
    keyb_clk = 1'b0; keyb_data = v;
    repeat (HP) @(negedge clk);
    keyb_clk = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_good, input bit stop);
    logic p;
    bit acc;
    p = par_good ? ~^b : ^b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(stop);
    keyb_data = 1'b1;
    repeat (HP) @(negedge clk);
    acc = stop;
`ifdef PS2_PARITY_CHECK_EN
    acc = acc && par_good;
`endif
    if (acc) model_byte(b);
  endtask

  task automatic key(input logic [7:0] b, input string tag);
    send_frame(b, 1'b1, 1'b1);
    check_all(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all("in_reset");
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check_all("idle");

    key(8'h7D, "mk7D");
    check("mk7D.const5", hex5, 7'h10);
    check("mk7D.const7", hex7, 7'h78);
    check("mk7D.const6", hex6, 7'h21);
    key(8'hF0, "brkF0");
    check("brkF0.const7", hex7, 7'h0E);
    check("brkF0.const6", hex6, 7'h40);
    key(8'h7D, "brk7D");
    key(8'h7D, "mk7D_2");
    key(8'hF0, "brk2");
    key(8'h7D, "brk7D_2");
    key(8'h79, "plus");
    key(8'hF0, "brk3");
    key(8'h79, "brk79");
    send_frame(8'h70, 1'b0, 1'b1);
    check_all("d0_badpar");
    key(8'hF0, "brk4");
    send_frame(8'h70, 1'b0, 1'b1);
    check_all("brk70_badpar");
    key(8'h55, "eq");
`ifdef PS2_PARITY_CHECK_EN
    check("seq.const4", hex4, 7'h7F);
    check("seq.const1", hex1, 7'h7F);
`else
    check("seq.const4", hex4, 7'h40);
    check("seq.const1", hex1, 7'h40);
    check("seq.const0", hex0, 7'h10);
`endif
    key(8'hF0, "brk5");
    key(8'h55, "brk55");

    send_frame(8'h75, 1'b1, 1'b0);
    check_all("badstop");
    key(8'h75, "d8");
    key(8'hF0, "brk6");
    key(8'h75, "brk75");
    key(8'h76, "clear");
    check("clear.const5", hex5, 7'h7F);

    // idle glitch with data high must not open a frame
    keyb_clk = 1'b0; repeat (HP) @(negedge clk);
    keyb_clk = 1'b1; repeat (HP) @(negedge clk);
    key(8'h69, "after_glitch");

    // stall mid-frame past the timeout, then a clean frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    keyb_data = 1'b1;
    repeat (4200) @(negedge clk);
    check_all("timeout");
    key(8'h79, "after_tmo");

    // reset in the middle of a frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("midreset");
    keyb_data = 1'b1;
    reset = 1'b1;
    repeat (4 * HP) @(negedge clk);
    key(8'h7A, "after_rst");

    for (int n = 0; n < 150; n++) begin
      int c;
      logic [7:0] b;
      c = $urandom_range(0, 99);
      b = PICK[$urandom_range(0, 13)];
      if (c < 8)       b = 8'h76;
      else if (c < 20) b = 8'hF0;
      else if (c < 28) b = 8'($urandom);
      if (c >= 90)      send_frame(b, 1'b1, 1'b0);
      else if (c >= 82) send_frame(b, 1'b0, 1'b1);
      else              send_frame(b, 1'b1, 1'b1);
      check_all($sformatf("rnd%0d_%h", n, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
